// File: rtl/lu_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: op encodings and sizing limits.
package lu_pkg;

   localparam int unsigned OP_W       = 3;
   localparam int unsigned MAX_STAGES = 4;

   typedef logic [OP_W-1:0] lu_op_t;

   typedef enum logic [OP_W-1:0] {
      LU_AND  = 3'b000,
      LU_OR   = 3'b001,
      LU_XOR  = 3'b010,
      LU_XNOR = 3'b011,
      LU_NAND = 3'b100,
      LU_NOR  = 3'b101,
      LU_NOT  = 3'b110,
      LU_PASS = 3'b111
   } lu_op_e;

endpackage

// File: rtl/lu_stage.sv
// One elastic valid/data register slice. It loads from upstream whenever it is empty
// or its downstream neighbour takes the current beat this cycle.
module lu_stage
   import lu_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         valid_i,
   input  logic [W-1:0] data_i,
   output logic         ready_o,
   output logic         valid_o,
   output logic [W-1:0] data_o,
   input  logic         ready_i
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   // Ready depends only on local state and downstream ready, never on valid_i.
   assign ready_o = !valid_q || ready_i;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (ready_o) begin
         valid_d = valid_i;
         if (valid_i) begin
            data_d = data_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit feeding a STAGES-deep elastic pipeline of lu_stage slices.
// Define LU_PARITY_EN to add a pipelined parity output (XOR-reduction of the result).
module logic_unit_pipe
   import lu_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero
`ifdef LU_PARITY_EN
   ,
   output logic             parity
`endif
);

`ifdef LU_PARITY_EN
   localparam int unsigned PW = WIDTH + 2;
`else
   localparam int unsigned PW = WIDTH + 1;
`endif

   if (STAGES < 1 || STAGES > MAX_STAGES || WIDTH < 1 || WIDTH > 64) begin : g_bad_cfg
      $error("logic_unit_pipe: WIDTH must be 1..64 and STAGES 1..%0d", MAX_STAGES);
   end

   logic [WIDTH-1:0] res;
   logic [PW-1:0]    payload;

   always_comb begin
      res = '0;
      case (op)
         LU_AND:  res = a & b;
         LU_OR:   res = a | b;
         LU_XOR:  res = a ^ b;
         LU_XNOR: res = ~(a ^ b);
         LU_NAND: res = ~(a & b);
         LU_NOR:  res = ~(a | b);
         LU_NOT:  res = ~a;
         LU_PASS: res = a;
      endcase
   end

`ifdef LU_PARITY_EN
   assign payload = {^res, ~|res, res};
`else
   assign payload = {~|res, res};
`endif

   // Index k is the link feeding stage k; index STAGES is the output port side.
   logic [STAGES:0] vld;
   logic [STAGES:0] rdy;
   logic [PW-1:0]   pay [0:STAGES];

   assign vld[0]      = in_valid;
   assign pay[0]      = payload;
   assign rdy[STAGES] = out_ready;
   assign in_ready    = rdy[0];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      lu_stage #(.W(PW)) u_stage (
         .clk     (clk),
         .reset   (reset),
         .valid_i (vld[k]),
         .data_i  (pay[k]),
         .ready_o (rdy[k]),
         .valid_o (vld[k+1]),
         .data_o  (pay[k+1]),
         .ready_i (rdy[k+1])
      );
   end

   assign out_valid = vld[STAGES];
   assign y         = pay[STAGES][WIDTH-1:0];
   assign zero      = pay[STAGES][WIDTH];
`ifdef LU_PARITY_EN
   assign parity    = pay[STAGES][WIDTH+1];
`endif

endmodule
